e1_rx_buf_pack: RTL
===================

# e1_rx_buf_pack

Packs the per-timeslot byte stream from the E1 RX buffer interface (`buf_rx_*` / `buf_rx_rdy`) into 32-bit words with byte enables and writes them to a shared frame memory through a simple req/ack write port. It sits directly downstream of the E1 wishbone top-level, between its RX buffer write interface and the memory arbiter. A 2-entry word FIFO absorbs arbiter latency. Drops and misalignment are reported through sticky flags.

## Interface

**Parameters**
- `MFW`, default 7: multiframe index width. Must match the E1 core's `MFW`.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `buf_rx_data` input 8: timeslot byte.
- `buf_rx_ts` input 5: timeslot index 0..31.
- `buf_rx_frame` input 4: frame index within the multiframe, 0..15.
- `buf_rx_mf` input MFW: multiframe index.
- `buf_rx_we` input 1: byte strobe, one cycle per byte.
- `buf_rx_rdy` output 1: block can accept a byte this cycle.
- `mem_addr` output MFW+7: word address `{mf, frame, ts[4:2]}`.
- `mem_wdata` output 32: packed word. Lane *n* (bits 8n+7:8n) holds the byte with `ts[1:0]`=n.
- `mem_be` output 4: byte enables, bit *n* for lane *n*.
- `mem_req` output 1: write request.
- `mem_ack` input 1: write accepted this cycle.
- `stat_clr` input 1: clears the sticky flags.
- `stat_ovf` output 1: sticky; a byte was dropped because the block was not ready.
- `stat_misalign` output 1: sticky; pending lanes were discarded on a word-address change.

## Operation

**Accumulator.** Holds a 32-bit data register, a 4-bit lane-valid mask, and a word tag of MFW+7 bits.

**Byte acceptance.** A byte is accepted when `buf_rx_we & buf_rx_rdy`. Let W = `{mf, frame, ts[4:2]}` of the incoming byte.
- If the mask is non-zero and the tag ≠ W:
  - clear the mask,
  - set `stat_misalign`,
  - then process the byte as the first byte of word W.
- Write the byte into lane `ts[1:0]`, set the corresponding mask bit, and set tag = W.
- If `ts[1:0]`=3:
  - push {tag, data including this byte, mask including this bit} into the FIFO,
  - clear the mask in the same cycle.

**Flushing.** Words are pushed only on lane 3. A partial word is never flushed on its own; it is either completed by lane 3 or discarded by misalignment.

**FIFO.** 2 entries, first-in first-out. The head drives `mem_addr`, `mem_wdata` and `mem_be`. `mem_req` = FIFO not empty.

**Memory handshake.**
- Head fields are held stable while `mem_req`=1 and `mem_ack`=0.
- `mem_ack` is ignored when `mem_req`=0.
- `mem_ack`=1 with `mem_req`=1 pops the head. The next entry, if any, is presented in the following cycle.

**Ready and overflow.**
- `buf_rx_rdy` = FIFO level < 2. It is combinational from the level register and does not depend on `mem_ack`.
- `buf_rx_we` while `buf_rx_rdy`=0: the byte is discarded, the accumulator is unchanged, and `stat_ovf` is set.

**Simultaneous events.**
- Push and pop in the same cycle: level unchanged, and ordering is preserved.
- `stat_clr` and a set event in the same cycle: the set wins.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0,
  - `buf_rx_rdy`=1,
  - `stat_ovf`=0, `stat_misalign`=0,
  - accumulator mask = 0, FIFO empty.
- Latency: byte with `ts[1:0]`=3 accepted in cycle N, FIFO empty → `mem_req`=1 with that word in cycle N+1.
- Minimum byte spacing is 1 cycle. Back-to-back strobes are supported at full rate as long as `buf_rx_rdy`=1.
- FIFO level becomes 2 in cycle N → `buf_rx_rdy`=0 from cycle N+1 until the cycle after a pop.
- `rst_n` assertion mid-operation immediately clears the FIFO, accumulator and flags; `mem_req` drops asynchronously. Deassertion is synchronised by the system, so no internal synchroniser is needed.

## Test plan
- **Aligned packing.** Bytes 0x10..0x13 at ts 0..3, frame 5, mf 2, `mem_ack` tied high → one write: `mem_addr`=`{2,5,0}`, `mem_wdata`=0x13121110, `mem_be`=0xF, `mem_req` high for exactly 1 cycle, one cycle after the ts 3 byte.
- **Full frame.** ts 0..31 at full rate, `mem_ack`=1 → 8 writes with word index 0..7, all `mem_be`=0xF, `buf_rx_rdy` never low, no flags set.
- **Backpressure.** `mem_ack`=0; send 3 complete words (12 bytes) → `buf_rx_rdy` falls after the 2nd word. Bytes 9..12 are dropped and `stat_ovf`=1. Releasing `mem_ack` produces exactly 2 writes, in order.
- **Misalignment.** ts 0,1 of frame 3, then ts 0..3 of frame 4 → `stat_misalign`=1. Exactly one write, for frame 4, with `mem_be`=0xF. `stat_clr` then clears the flag.
- **Sparse lanes.** ts 2,3 only → one write with `mem_be`=0xC and lanes 0 and 1 don't-care.
- **Reset mid-operation.** `rst_n` low while `mem_req`=1 with 2 entries queued → `mem_req`=0 immediately. After release, `buf_rx_rdy`=1 and no stale write occurs.

Source files
------------

// File: rtl/e1_rx_buf_pack_if.sv
// RX-buffer byte stream and frame-memory write port of e1_rx_buf_pack.
// master = surrounding system (E1 core + arbiter), slave = the packer.
interface e1_rx_buf_pack_if #(
    parameter int unsigned MFW = 7
);
    logic [7:0]     buf_rx_data;
    logic [4:0]     buf_rx_ts;
    logic [3:0]     buf_rx_frame;
    logic [MFW-1:0] buf_rx_mf;
    logic           buf_rx_we;
    logic           buf_rx_rdy;

    logic [MFW+6:0] mem_addr;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_be;
    logic           mem_req;
    logic           mem_ack;

    modport master (
        output buf_rx_data, buf_rx_ts, buf_rx_frame, buf_rx_mf, buf_rx_we,
        input  buf_rx_rdy,
        input  mem_addr, mem_wdata, mem_be, mem_req,
        output mem_ack
    );

    modport slave (
        input  buf_rx_data, buf_rx_ts, buf_rx_frame, buf_rx_mf, buf_rx_we,
        output buf_rx_rdy,
        output mem_addr, mem_wdata, mem_be, mem_req,
        input  mem_ack
    );
endinterface

// File: rtl/e1_rx_buf_pack.sv
// Packs E1 RX timeslot bytes into 32-bit words with byte enables and queues
// them in a 2-entry FIFO towards a req/ack frame-memory write port.
module e1_rx_buf_pack #(
    parameter int unsigned MFW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    e1_rx_buf_pack_if.slave   bus,
    input  logic              stat_clr,
    output logic              stat_ovf,
    output logic              stat_misalign
);
    localparam int unsigned AW = MFW + 7;

    logic [31:0]   acc_data_q, acc_data_d;
    logic [3:0]    acc_mask_q, acc_mask_d;
    logic [AW-1:0] acc_tag_q, acc_tag_d;

    logic [AW-1:0] fifo_addr_q [2];
    logic [31:0]   fifo_data_q [2];
    logic [3:0]    fifo_be_q   [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    level_q, level_d;

    logic          ovf_q, ovf_d, mis_q, mis_d;

    logic          rdy, accept, push, pop, misalign_hit;
    logic [1:0]    lane;
    logic [AW-1:0] word_addr;
    logic [31:0]   merged_data;
    logic [3:0]    merged_mask;

    assign rdy          = (level_q != 2'd2);
    assign accept       = bus.buf_rx_we & rdy;
    assign lane         = bus.buf_rx_ts[1:0];
    assign word_addr    = {bus.buf_rx_mf, bus.buf_rx_frame, bus.buf_rx_ts[4:2]};
    assign misalign_hit = accept && (acc_mask_q != '0) && (acc_tag_q != word_addr);
    assign push         = accept && (lane == 2'd3);
    assign pop          = (level_q != 2'd0) && bus.mem_ack;

    // Lanes outside the mask keep stale data; they leave only as don't-care bytes.
    always_comb begin
        merged_data = acc_data_q;
        merged_data[{lane, 3'b000} +: 8] = bus.buf_rx_data;
        merged_mask = (misalign_hit ? 4'b0000 : acc_mask_q) | (4'b0001 << lane);
    end

    always_comb begin
        acc_data_d = acc_data_q;
        acc_mask_d = acc_mask_q;
        acc_tag_d  = acc_tag_q;
        if (accept) begin
            acc_data_d = merged_data;
            acc_tag_d  = word_addr;
            acc_mask_d = push ? 4'b0000 : merged_mask;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase
    end

    // A set event in the same cycle as stat_clr takes priority.
    assign ovf_d = (bus.buf_rx_we & ~rdy) | (ovf_q & ~stat_clr);
    assign mis_d = misalign_hit | (mis_q & ~stat_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data_q <= '0;
            acc_mask_q <= '0;
            acc_tag_q  <= '0;
            ovf_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_mask_q <= acc_mask_d;
            acc_tag_q  <= acc_tag_d;
            ovf_q      <= ovf_d;
            mis_q      <= mis_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_be_q[i]   <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            level_q  <= '0;
        end else begin
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= word_addr;
                fifo_data_q[wr_ptr_q] <= merged_data;
                fifo_be_q[wr_ptr_q]   <= merged_mask;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            level_q <= level_d;
        end
    end

    assign bus.buf_rx_rdy = rdy;
    assign bus.mem_req    = (level_q != 2'd0);
    assign bus.mem_addr   = fifo_addr_q[rd_ptr_q];
    assign bus.mem_wdata  = fifo_data_q[rd_ptr_q];
    assign bus.mem_be     = fifo_be_q[rd_ptr_q];
    assign stat_ovf       = ovf_q;
    assign stat_misalign  = mis_q;
endmodule
